fb_scanout_reader: RTL

Read side of the 160×120×24-bit virtual frame buffer. Game logic writes that buffer through the address/data/write-strobe port. This block takes the VGA timing outputs (`x`, `y`, `active_pixels`, `frame_done`) and does three things:
- generates read addresses incrementally, with no multiplier;
- drives a synchronous-read RAM port;
- returns a latency-aligned 24-bit RGB pixel stream with a valid flag to the DAC path.

Each virtual pixel is replicated 4×4 on the 640×480 raster.

---
 rtl/fb_scanout_reader_if.sv | 10 +
 rtl/fb_scanout_reader.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fb_scanout_reader_if.sv
// Synchronous-read RAM port between the scanout reader (master) and the
// frame buffer read side (slave).
interface fb_scanout_reader_if;
  logic        rd_en;
  logic [14:0] rd_addr;
  logic [23:0] rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/fb_scanout_reader.sv
// Scanout reader for the 160x120x24 virtual frame buffer: incremental address
// generation, RAM read issue and latency-aligned pixel output.
// Optional test-pattern source enabled by FB_SCANOUT_TESTPATTERN_EN.
module fb_scanout_reader #(
  parameter int VIRT_W         = 160,
  parameter int VIRT_H         = 120,
  parameter int PIX_SCALE_LOG2 = 2,
  parameter int RD_LATENCY     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       active_pixels,
  input  logic                       frame_done,
  input  logic [9:0]                 x,
  input  logic [9:0]                 y,
`ifdef FB_SCANOUT_TESTPATTERN_EN
  input  logic [1:0]                 pattern_sel,
`endif
  fb_scanout_reader_if.master        ram,
  output logic [23:0]                pix_rgb,
  output logic                       pix_valid,
  output logic                       fault
);

  localparam logic [9:0] RASTER_W = 10'(VIRT_W << PIX_SCALE_LOG2);
  localparam logic [9:0] RASTER_H = 10'(VIRT_H << PIX_SCALE_LOG2);

  typedef enum logic [1:0] {IDLE, SCAN, FAULT} state_t;

  // One entry per raster slot travelling alongside the RAM read.
  typedef struct packed {
    logic       valid;
    logic       black;
`ifdef FB_SCANOUT_TESTPATTERN_EN
    logic [1:0] sel;
    logic [2:0] bar;
    logic       chk;
`endif
  } slot_t;

  state_t                state_q, state_d;
  logic [6:0]            vrow;
  logic [14:0]           row_base;
  logic [14:0]           next_base;
  logic [9:0]            vx, vy;
  logic                  range_err, row_same, row_next;
  logic                  err, do_read;
  slot_t                 slot_in, slot_out;
  slot_t [RD_LATENCY:0]  pipe;
  logic [23:0]           src_rgb;

  assign vx        = x >> PIX_SCALE_LOG2;
  assign vy        = y >> PIX_SCALE_LOG2;
  assign range_err = (x >= RASTER_W) || (y >= RASTER_H);
  assign row_same  = (vy == {3'b000, vrow});
  assign row_next  = (vy == {3'b000, vrow} + 10'd1);
  assign next_base = row_next ? row_base + 15'(VIRT_W) : row_base;
  assign slot_out  = pipe[RD_LATENCY];

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    err     = 1'b0;
    do_read = 1'b0;
    slot_in = '0;
`ifdef FB_SCANOUT_TESTPATTERN_EN
    slot_in.sel = pattern_sel;
    slot_in.bar = x[9:7];
    slot_in.chk = x[2] ^ y[2];
`endif
    if (frame_done) begin
      // Frame boundary wins over a coincident active pixel: no read, invalid slot.
      state_d = SCAN;
    end else if (active_pixels) begin
      unique case (state_q)
        SCAN: begin
          err           = range_err || !(row_same || row_next);
          do_read       = !err;
          state_d       = err ? FAULT : SCAN;
          slot_in.valid = 1'b1;
          slot_in.black = err;
        end
        FAULT: begin
          slot_in.valid = 1'b1;
          slot_in.black = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef FB_SCANOUT_TESTPATTERN_EN
  always_comb begin
    unique case (slot_out.sel)
      2'd1:    src_rgb = {{8{slot_out.bar[2]}}, {8{slot_out.bar[1]}}, {8{slot_out.bar[0]}}};
      2'd2:    src_rgb = {24{slot_out.chk}};
      2'd3:    src_rgb = 24'hFF00FF;
      default: src_rgb = ram.rd_data;
    endcase
  end
`else
  assign src_rgb = ram.rd_data;
`endif

  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ram.rd_en   <= 1'b0;
      ram.rd_addr <= '0;
      row_base    <= '0;
      vrow        <= '0;
      // NOTE: the slot pipeline is reset so valid bits in flight at reset
      // cannot reach the DAC afterwards.
      pipe        <= '0;
      pix_rgb     <= '0;
      pix_valid   <= 1'b0;
      fault       <= 1'b0;
    end else begin
      ram.rd_en <= do_read;
      if (do_read) ram.rd_addr <= next_base + 15'(vx);

      if (frame_done) begin
        row_base <= '0;
        vrow     <= '0;
      end else if (do_read && row_next) begin
        row_base <= next_base;
        vrow     <= vrow + 7'd1;
      end

      if (err) fault <= 1'b1;

      pipe      <= {pipe[RD_LATENCY-1:0], slot_in};
      pix_valid <= slot_out.valid;
      pix_rgb   <= (slot_out.valid && !slot_out.black) ? src_rgb : '0;
    end
  end

endmodule
